// File: rtl/bp_spi_host.sv
`default_nettype none
// ============================================================================
// Module   : bp_spi_host
// Purpose  : BlackPearl control-link initiator. It shifts a command out MSB-first
//            and captures the chip's reply. Define BP_HOST_EOF_WAIT_EN to wait
//            for the chip's EoF strobe (bounded by TIMEOUT) before responding.
// Revision : 1.0
// ============================================================================
module bp_spi_host #(
    parameter int FRAME_W  = 16,
    parameter int RX_DELAY = 1,
    parameter int GAP      = 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [FRAME_W-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [FRAME_W-1:0] rsp_data,
    output logic               rsp_timeout,
    output logic               spi_ss,
    output logic               spi_FtoC,
    input  logic               spi_CtoF,
    input  logic               EoF
);

    localparam int CNT_MAX = (FRAME_W + RX_DELAY > GAP) ? (FRAME_W + RX_DELAY) : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHIFT    = 3'd1,
        S_TAIL     = 3'd2,
        S_GAP      = 3'd3,
        S_WAIT_EOF = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [FRAME_W-1:0] rx_q, rx_d;
    logic [FRAME_W-1:0] rsp_data_q, rsp_data_d;
    logic               ftoc_q, ftoc_d;
    logic               ss_q, ss_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;

`ifdef BP_HOST_EOF_WAIT_EN
    localparam int TO_W = $clog2(TIMEOUT);
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rsp_data_d = rsp_data_q;
        ftoc_d     = ftoc_q;
`ifdef BP_HOST_EOF_WAIT_EN
        to_cnt_d   = to_cnt_q;
        timeout_d  = timeout_q;
`endif

        // One shared counter spans SHIFT and TAIL, so the sample window is cnt >= RX_DELAY.
        if ((state_q == S_SHIFT || state_q == S_TAIL) && cnt_q >= CNT_W'(RX_DELAY)) begin
            rx_d = {rx_q[FRAME_W-2:0], spi_CtoF};
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    ftoc_d  = cmd_data[FRAME_W-1];
                    tx_d    = {cmd_data[FRAME_W-2:0], 1'b0};
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                    ftoc_d = 1'b0;
                    if (RX_DELAY == 0) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_TAIL;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
                    ftoc_d = tx_q[FRAME_W-1];
                    tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            S_TAIL: begin
                if (cnt_q == CNT_W'(FRAME_W + RX_DELAY - 1)) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP - 1)) begin
                    cnt_d = '0;
`ifdef BP_HOST_EOF_WAIT_EN
                    state_d  = S_WAIT_EOF;
                    to_cnt_d = '0;
`else
                    state_d    = S_RESP;
                    rsp_data_d = rx_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef BP_HOST_EOF_WAIT_EN
            S_WAIT_EOF: begin
                // EoF on the final count still counts as a clean finish.
                if (EoF) begin
                    state_d    = S_RESP;
                    timeout_d  = 1'b0;
                    rsp_data_d = rx_q;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d    = S_RESP;
                    timeout_d  = 1'b1;
                    rsp_data_d = rx_q;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
`endif
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ss_d    = (state_d != S_SHIFT);
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rsp_data_q <= '0;
            ftoc_q     <= 1'b0;
            ss_q       <= 1'b1;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rsp_data_q <= rsp_data_d;
            ftoc_q     <= ftoc_d;
            ss_q       <= ss_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
        end
    end

`ifdef BP_HOST_EOF_WAIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign rsp_timeout = timeout_q;
`else
    logic unused_eof;
    assign unused_eof  = EoF ^ (TIMEOUT > 1);
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_data  = rsp_data_q;
    assign spi_ss    = ss_q;
    assign spi_FtoC  = ftoc_q;

endmodule
`default_nettype wire
